// File: rtl/uart_line_responder.sv
// Line-echo endpoint on the UART FIFO interface: buffers a CR-terminated line and
// answers it uppercased with CR LF, or with "!" CR LF when the line overflows.
module uart_line_responder #(
  parameter int MAX_LEN = 16,
  parameter int ADDR_W  = 4,
  parameter int DBIT    = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx_empty,
  input  logic [DBIT-1:0] r_data,
  output logic            rd_uart,
  input  logic            tx_full,
  output logic            wr_uart,
  output logic [DBIT-1:0] w_data,
  output logic            busy,
  output logic            line_done,
  output logic            ovf_err,
  output logic [15:0]     line_cnt
);

  typedef enum logic [2:0] {
    ST_COLLECT  = 3'd0,
    ST_DROP     = 3'd1,
    ST_SEND     = 3'd2,
    ST_SEND_ERR = 3'd3,
    ST_SEND_CR  = 3'd4,
    ST_SEND_LF  = 3'd5
  } state_t;

  localparam logic [DBIT-1:0]   CH_CR    = DBIT'(8'h0D);
  localparam logic [DBIT-1:0]   CH_LF    = DBIT'(8'h0A);
  localparam logic [DBIT-1:0]   CH_BANG  = DBIT'(8'h21);
  localparam logic [ADDR_W:0]   LEN_MAX  = (ADDR_W+1)'(MAX_LEN);
  localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   LEN_ZERO = (ADDR_W+1)'(0);
  localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] IDX_ZERO = ADDR_W'(0);

  function automatic logic [DBIT-1:0] to_upper(input logic [DBIT-1:0] c);
    if (c >= DBIT'(8'h61) && c <= DBIT'(8'h7A)) begin
      to_upper = c - DBIT'(8'h20);
    end else begin
      to_upper = c;
    end
  endfunction

  state_t          state_r;
  logic [ADDR_W:0] len_r;
  logic [ADDR_W-1:0] idx_r;
  logic [15:0]     line_cnt_r;
  logic [DBIT-1:0] line_buf_r [MAX_LEN];

  logic            pop_s;
  logic            push_s;
  logic [DBIT-1:0] w_data_s;
  logic            is_cr_s;
  logic            is_lf_s;
  logic            full_s;
  logic            last_s;
  logic            store_s;

  assign is_cr_s = (r_data == CH_CR);
  assign is_lf_s = (r_data == CH_LF);
  assign full_s  = (len_r == LEN_MAX);
  assign last_s  = ({1'b0, idx_r} == (len_r - LEN_ONE));
  assign store_s = pop_s && (state_r == ST_COLLECT) && !is_cr_s && !is_lf_s && !full_s;

  // FIFO handshakes and transmit character decoded from the registered state
  always_comb begin
    pop_s    = 1'b0;
    push_s   = 1'b0;
    w_data_s = {DBIT{1'b0}};
    case (state_r)
      ST_COLLECT, ST_DROP: begin
        pop_s = reset && !rx_empty;
      end
      ST_SEND: begin
        push_s   = !tx_full;
        w_data_s = to_upper(line_buf_r[idx_r]);
      end
      ST_SEND_ERR: begin
        push_s   = !tx_full;
        w_data_s = CH_BANG;
      end
      ST_SEND_CR: begin
        push_s   = !tx_full;
        w_data_s = CH_CR;
      end
      ST_SEND_LF: begin
        push_s   = !tx_full;
        w_data_s = CH_LF;
      end
      default: begin
        pop_s    = 1'b0;
        push_s   = 1'b0;
        w_data_s = {DBIT{1'b0}};
      end
    endcase
  end

  assign rd_uart   = pop_s;
  assign wr_uart   = push_s;
  assign w_data    = w_data_s;
  assign busy      = (state_r != ST_COLLECT);
  assign line_done = push_s && (state_r == ST_SEND_LF);
  assign ovf_err   = pop_s && (state_r == ST_COLLECT) && !is_cr_s && !is_lf_s && full_s;
  assign line_cnt  = line_cnt_r;

  // Line buffer write port; contents survive reset
  always_ff @(posedge clk) begin
    if (store_s) begin
      line_buf_r[len_r[ADDR_W-1:0]] <= r_data;
    end
  end

  // Responder state machine, line length, send index and line counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_COLLECT;
      len_r      <= LEN_ZERO;
      idx_r      <= IDX_ZERO;
      line_cnt_r <= 16'd0;
    end else begin
      case (state_r)
        ST_COLLECT: begin
          if (pop_s) begin
            if (is_cr_s) begin
              idx_r   <= IDX_ZERO;
              state_r <= (len_r == LEN_ZERO) ? ST_SEND_CR : ST_SEND;
            end else if (!is_lf_s) begin
              if (full_s) begin
                state_r <= ST_DROP;
              end else begin
                len_r <= len_r + LEN_ONE;
              end
            end
          end
        end
        ST_DROP: begin
          if (pop_s && is_cr_s) begin
            state_r <= ST_SEND_ERR;
          end
        end
        ST_SEND: begin
          if (push_s) begin
            idx_r <= idx_r + IDX_ONE;
            if (last_s) begin
              state_r <= ST_SEND_CR;
            end
          end
        end
        ST_SEND_ERR: begin
          if (push_s) begin
            state_r <= ST_SEND_CR;
          end
        end
        ST_SEND_CR: begin
          if (push_s) begin
            state_r <= ST_SEND_LF;
          end
        end
        ST_SEND_LF: begin
          if (push_s) begin
            line_cnt_r <= line_cnt_r + 16'd1;
            len_r      <= LEN_ZERO;
            idx_r      <= IDX_ZERO;
            state_r    <= ST_COLLECT;
          end
        end
        default: begin
          state_r <= ST_COLLECT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_line_responder.sv
// Scoreboard bench: a line-level reference model queues expected tx bytes and
// overflow flags; a monitor checks every pop and push the responder performs.
module tb_uart_line_responder;
  localparam int MAX_LEN = 16;
  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx_empty = 1'b1;
  logic [7:0]  r_data = 8'h00;
  logic        rd_uart;
  logic        tx_full = 1'b0;
  logic        wr_uart;
  logic [7:0]  w_data;
  logic        busy;
  logic        line_done;
  logic        ovf_err;
  logic [15:0] line_cnt;

  uart_line_responder #(.MAX_LEN(MAX_LEN), .ADDR_W(4), .DBIT(8)) dut (
    .clk(clk), .reset(reset), .rx_empty(rx_empty), .r_data(r_data), .rd_uart(rd_uart),
    .tx_full(tx_full), .wr_uart(wr_uart), .w_data(w_data), .busy(busy),
    .line_done(line_done), .ovf_err(ovf_err), .line_cnt(line_cnt)
  );

  always #5 clk = ~clk;

  logic [7:0] rx_q[$];
  logic [7:0] exp_tx_q[$];
  bit         exp_ovf_q[$];
  int vectors = 0, miscompares = 0;
  int exp_lines = 0, owed = 0, stall_left = 0, push_in_line = 0, stall_cycles = 0;
  bit stall_arm = 0, rand_stall = 0, mid_resp = 0, in_stall = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] up(input logic [7:0] c);
    return (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
  endfunction

  function automatic bq_t s2q(input string s, input bit cr);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    if (cr) q.push_back(8'h0D);
    return q;
  endfunction

  // Reference model: the whole line decides the answer
  task automatic add_line(input bq_t ln);
    int k = 0;
    bit term = 0;
    bq_t resp;
    foreach (ln[i]) begin
      rx_q.push_back(ln[i]);
      if (ln[i] == 8'h0D) begin
        term = 1;
        exp_ovf_q.push_back(1'b0);
      end else if (ln[i] == 8'h0A) begin
        exp_ovf_q.push_back(1'b0);
      end else begin
        k++;
        exp_ovf_q.push_back(k == MAX_LEN + 1);
        if (k <= MAX_LEN) resp.push_back(up(ln[i]));
      end
    end
    if (term) begin
      if (k > MAX_LEN) exp_tx_q.push_back(8'h21);
      else foreach (resp[i]) exp_tx_q.push_back(resp[i]);
      exp_tx_q.push_back(8'h0D);
      exp_tx_q.push_back(8'h0A);
      exp_lines++;
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((rx_q.size() != 0 || exp_tx_q.size() != 0 || owed != 0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) chk("drain_timeout", 32'd1, 32'd0);
    repeat (3) @(negedge clk);
    chk("busy_idle", {31'd0, busy}, 32'd0);
    chk("line_cnt", {16'd0, line_cnt}, exp_lines & 32'hFFFF);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_rd_uart", {31'd0, rd_uart}, 32'd0);
    chk("rst_wr_uart", {31'd0, wr_uart}, 32'd0);
    chk("rst_w_data", {24'd0, w_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_line_done", {31'd0, line_done}, 32'd0);
    chk("rst_ovf_err", {31'd0, ovf_err}, 32'd0);
    chk("rst_line_cnt", {16'd0, line_cnt}, 32'd0);
  endtask

  // rx FIFO and tx back-pressure model, inputs change 1 time unit after the edge
  initial begin
    bit pop_now;
    forever begin
      @(negedge clk);
      pop_now = reset && rd_uart;
      @(posedge clk);
      #1;
      if (pop_now && rx_q.size() > 0) void'(rx_q.pop_front());
      rx_empty = (rx_q.size() == 0);
      r_data   = rx_empty ? 8'h00 : rx_q[0];
      if (stall_left > 0) begin
        tx_full = 1'b1;
        in_stall = 1'b1;
        stall_left--;
      end else begin
        in_stall = 1'b0;
        tx_full  = rand_stall ? ($urandom_range(0, 3) == 0) : 1'b0;
      end
    end
  end

  // Monitor: pops and compares against the scoreboard whenever the DUT acts
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (wr_uart) begin
          if (exp_tx_q.size() == 0) begin
            chk("tx_unexpected", {24'd0, w_data}, 32'h100);
          end else begin
            e = exp_tx_q.pop_front();
            chk("tx_byte", {24'd0, w_data}, {24'd0, e});
            chk("line_done", {31'd0, line_done}, {31'd0, (e == 8'h0A)});
            mid_resp = (e != 8'h0A);
            push_in_line++;
            if (stall_arm && push_in_line == 2) begin
              stall_left = 10;
              stall_arm  = 0;
            end
            if (e == 8'h0A) begin
              owed--;
              push_in_line = 0;
            end
          end
        end else begin
          if (line_done) chk("line_done_idle", 32'd1, 32'd0);
          if (mid_resp && !tx_full) chk("tx_gap", 32'd1, 32'd0);
        end
        if (rd_uart) begin
          chk("rd_wr_overlap", {31'd0, wr_uart}, 32'd0);
          if (rx_q.size() == 0 || exp_ovf_q.size() == 0) begin
            chk("pop_empty", 32'd1, 32'd0);
          end else begin
            chk("ovf_err", {31'd0, ovf_err}, {31'd0, exp_ovf_q.pop_front()});
            chk("pop_while_owed", {31'd0, (owed > 0)}, 32'd0);
            if (rx_q[0] == 8'h0D) owed++;
          end
        end else if (ovf_err) begin
          chk("ovf_idle", 32'd1, 32'd0);
        end
        if (in_stall) begin
          stall_cycles++;
          chk("stall_wr", {31'd0, wr_uart}, 32'd0);
          chk("stall_rd", {31'd0, rd_uart}, 32'd0);
        end
      end
    end
  end

  // Stimulus: directed lines, mid-line reset, then random lines with stalls
  initial begin
    bq_t ln;
    repeat (2) @(negedge clk);
    chk_reset_outputs();
    @(posedge clk); #3 reset = 1'b1;

    add_line(s2q("abc", 1'b1));
    drain();
    add_line(s2q("", 1'b1));
    add_line(s2q("a\nB1", 1'b1));
    drain();
    add_line(s2q("xxxxxxxxxxxxxxxx", 1'b1));
    drain();
    add_line(s2q("xxxxxxxxxxxxxxxxxy", 1'b1));
    add_line(s2q("z", 1'b1));
    drain();

    stall_arm = 1;
    add_line(s2q("hello", 1'b1));
    add_line(s2q("pq", 1'b1));
    drain();
    chk("stall_cycles", stall_cycles, 32'd10);

    add_line(s2q("ab", 1'b0));
    drain();
    @(posedge clk); #3 reset = 1'b0;
    exp_lines = 0;
    repeat (2) begin
      @(negedge clk);
      chk_reset_outputs();
    end
    @(posedge clk); #3 reset = 1'b1;
    add_line(s2q("c", 1'b1));
    drain();

    rand_stall = 1;
    for (int n = 0; n < 40; n++) begin
      int len;
      logic [7:0] c;
      ln.delete();
      len = $urandom_range(0, 20);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 7) == 0) begin
          c = 8'h0A;
        end else begin
          c = 8'($urandom_range(0, 255));
          if (c == 8'h0D || c == 8'h0A) c = 8'h61;
        end
        ln.push_back(c);
      end
      ln.push_back(8'h0D);
      add_line(ln);
      if (n % 10 == 9) drain();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
